// File: rtl/rgb_hsv_pkg.sv
// rtl/rgb_hsv_pkg.sv - shared constants and types for the RGB to HSV pipeline
package rgb_hsv_pkg;

  // Hue sector starts on the 0..255 hue circle; the sector span equals HUE_SECTOR_G.
  localparam int HUE_SECTOR_R = 0;
  localparam int HUE_SECTOR_G = 85;
  localparam int HUE_SECTOR_B = 170;
  localparam int HUE_FULL     = 255;

  // Input sample to output, counted in enabled clock cycles.
  localparam int LATENCY      = 12;

  // One quotient bit per divider stage; both quotients fit in 8 bits.
  localparam int DIV_STAGES   = 8;

  typedef enum logic [1:0] {
    SECTOR_R,
    SECTOR_G,
    SECTOR_B
  } hue_sector_e;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  // Values that ride alongside the dividers to the output stage.
  typedef struct packed {
    logic [7:0] v;
    logic       h_zero;
    logic       s_zero;
  } side_t;

  function automatic logic [7:0] sector_offset(input hue_sector_e sector);
    case (sector)
      SECTOR_G: return 8'(HUE_SECTOR_G);
      SECTOR_B: return 8'(HUE_SECTOR_B);
      default:  return 8'(HUE_SECTOR_R);
    endcase
  endfunction

endpackage

// File: rtl/rgb_to_hsv_if.sv
// rtl/rgb_to_hsv_if.sv - pixel and sync bundle into and out of the converter
interface rgb_to_hsv_if;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] H;
  logic [7:0] S;
  logic [7:0] V;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;

  // Video source side.
  modport master (
    output de_in, hsync_in, vsync_in, red, green, blue,
    input  H, S, V, de_out, hsync_out, vsync_out
  );

  // Converter side.
  modport slave (
    input  de_in, hsync_in, vsync_in, red, green, blue,
    output H, S, V, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/div_pipe.sv
// rtl/div_pipe.sv - unsigned pipelined restoring divider, one quotient bit per stage
module div_pipe #(
  parameter int NW = 17,
  parameter int DW = 9,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [QW-1:0] quo
);

  // Callers guarantee num/den < 2**QW, so the top stage starts at den << (QW-1).
  localparam int CW = NW + DW;

  logic [NW-1:0] rem_q  [QW];
  logic [DW-1:0] den_q  [QW];
  logic [QW-1:0] quo_q  [QW];
  logic [NW-1:0] rem_in [QW];
  logic [DW-1:0] den_in [QW];
  logic [QW-1:0] quo_in [QW];
  logic [NW-1:0] rem_nx [QW];
  logic [QW-1:0] quo_nx [QW];
  logic [QW-1:0] fits;

  // Per stage: try subtracting the shifted divisor and set that quotient bit if it fits.
  always_comb begin
    logic [CW-1:0] trial;
    trial     = '0;
    fits      = '0;
    rem_in[0] = num;
    den_in[0] = den;
    quo_in[0] = '0;
    for (int i = 1; i < QW; i++) begin
      rem_in[i] = rem_q[i-1];
      den_in[i] = den_q[i-1];
      quo_in[i] = quo_q[i-1];
    end
    for (int i = 0; i < QW; i++) begin
      trial     = CW'(den_in[i]) << (QW - 1 - i);
      fits[i]   = CW'(rem_in[i]) >= trial;
      rem_nx[i] = fits[i] ? NW'(CW'(rem_in[i]) - trial) : rem_in[i];
      quo_nx[i] = quo_in[i] | (QW'(fits[i]) << (QW - 1 - i));
    end
  end

  // Stage registers; a low ce freezes every stage together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QW; i++) begin
        rem_q[i] <= '0;
        den_q[i] <= '0;
        quo_q[i] <= '0;
      end
    end else if (ce) begin
      for (int i = 0; i < QW; i++) begin
        rem_q[i] <= rem_nx[i];
        den_q[i] <= den_in[i];
        quo_q[i] <= quo_nx[i];
      end
    end
  end

  assign quo = quo_q[QW-1];

endmodule

// File: rtl/rgb_to_hsv.sv
// rtl/rgb_to_hsv.sv - pipelined RGB888 to HSV888 converter with aligned video syncs
module rgb_to_hsv
  import rgb_hsv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  rgb_to_hsv_if.slave px
);

  // Stages: 1 input, 2 max/min, 3 numerators, 4..11 dividers, 12 output = LATENCY.
  localparam logic signed [17:0] HUE_SPAN = 18'(HUE_SECTOR_G);
  localparam logic signed [17:0] HUE_WRAP = 18'(2 * HUE_FULL);

  logic [7:0]        r1, g1, b1;
  logic [7:0]        max_c, min_c;
  hue_sector_e       sector_c;
  logic signed [8:0] diff_c;
  logic [7:0]        max2, delta2;
  hue_sector_e       sector2;
  logic signed [8:0] diff2;
  logic signed [17:0] delta_x, offset_x, diff_x, hue_c;
  logic [16:0]       num_h3;
  logic [8:0]        den_h3;
  logic [15:0]       num_s3;
  logic [7:0]        den_s3;
  side_t             side3;
  side_t [DIV_STAGES-1:0] side_q;
  side_t             side_out;
  logic [7:0]        quo_h, quo_s;
  sync_t             sync_in;
  sync_t [LATENCY-1:0] sync_q;

  // Stage 1: capture the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
      g1 <= '0;
      b1 <= '0;
    end else if (ce) begin
      r1 <= px.red;
      g1 <= px.green;
      b1 <= px.blue;
    end
  end

  // Max/min and sector; strict compares give R priority over G over B on ties.
  always_comb begin
    max_c    = r1;
    sector_c = SECTOR_R;
    if (g1 > max_c) begin
      max_c    = g1;
      sector_c = SECTOR_G;
    end
    if (b1 > max_c) begin
      max_c    = b1;
      sector_c = SECTOR_B;
    end
    min_c = r1;
    if (g1 < min_c) min_c = g1;
    if (b1 < min_c) min_c = b1;
    case (sector_c)
      SECTOR_G: diff_c = $signed({1'b0, b1}) - $signed({1'b0, r1});
      SECTOR_B: diff_c = $signed({1'b0, r1}) - $signed({1'b0, g1});
      default:  diff_c = $signed({1'b0, g1}) - $signed({1'b0, b1});
    endcase
  end

  // Stage 2: register max, delta, sector and the sector's colour difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      max2    <= '0;
      delta2  <= '0;
      sector2 <= SECTOR_R;
      diff2   <= '0;
    end else if (ce) begin
      max2    <= max_c;
      delta2  <= max_c - min_c;
      sector2 <= sector_c;
      diff2   <= diff_c;
    end
  end

  // Hue numerator over denominator 2*delta; negative red hues wrap by a full circle.
  always_comb begin
    delta_x  = $signed({10'd0, delta2});
    offset_x = $signed({10'd0, sector_offset(sector2)});
    diff_x   = {{9{diff2[8]}}, diff2};
    hue_c    = 18'sd2 * delta_x * offset_x + HUE_SPAN * diff_x;
    if (sector2 == SECTOR_R && diff2[8]) hue_c = hue_c + HUE_WRAP * delta_x;
  end

  // Stage 3: divider operands plus the values that bypass the dividers.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_h3 <= '0;
      den_h3 <= '0;
      num_s3 <= '0;
      den_s3 <= '0;
      side3  <= '0;
    end else if (ce) begin
      num_h3 <= 17'(hue_c);
      den_h3 <= {delta2, 1'b0};
      num_s3 <= 16'(delta2) * 16'(HUE_FULL);
      den_s3 <= max2;
      side3  <= '{v: max2, h_zero: (delta2 == 8'd0), s_zero: (max2 == 8'd0)};
    end
  end

  div_pipe #(.NW(17), .DW(9), .QW(DIV_STAGES)) u_div_hue (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .num (num_h3),
    .den (den_h3),
    .quo (quo_h)
  );

  div_pipe #(.NW(16), .DW(8), .QW(DIV_STAGES)) u_div_sat (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .num (num_s3),
    .den (den_s3),
    .quo (quo_s)
  );

  // Stages 4..11: carry V and the zero-divisor flags in step with the dividers.
  always_ff @(posedge clk) begin
    if (rst) side_q <= '0;
    else if (ce) side_q <= {side_q[DIV_STAGES-2:0], side3};
  end

  assign side_out = side_q[DIV_STAGES-1];

  // Stage 12: outputs; zero divisors would give all-ones quotients, so force 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      px.H <= '0;
      px.S <= '0;
      px.V <= '0;
    end else if (ce) begin
      px.H <= side_out.h_zero ? 8'd0 : quo_h;
      px.S <= side_out.s_zero ? 8'd0 : quo_s;
      px.V <= side_out.v;
    end
  end

  assign sync_in = '{de: px.de_in, hsync: px.hsync_in, vsync: px.vsync_in};

  // Sync delay line, same depth and enable as the pixel path.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else if (ce) sync_q <= {sync_q[LATENCY-2:0], sync_in};
  end

  assign px.de_out    = sync_q[LATENCY-1].de;
  assign px.hsync_out = sync_q[LATENCY-1].hsync;
  assign px.vsync_out = sync_q[LATENCY-1].vsync;

endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb/tb_rgb_to_hsv.sv - directed self-checking bench for rgb_to_hsv
module tb_rgb_to_hsv;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rgb_to_hsv_if px ();

  rgb_to_hsv dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .px  (px)
  );

  localparam int NV = 13;
  // {R, G, B, H, S, V}
  int vec [NV][6] = '{
    '{  0,   0,  50, 170, 255,  50},
    '{  0,  50,   0,  85, 255,  50},
    '{ 50,   0,   0,   0, 255,  50},
    '{ 50, 100, 250, 159, 204, 250},
    '{178,  28, 192, 208, 217, 192},
    '{112, 112, 112,   0,   0, 112},
    '{  0,   0,   0,   0,   0,   0},
    '{255, 255, 255,   0,   0, 255},
    '{255,   0,   1, 254, 255, 255},
    '{255, 255,   0,  42, 255, 255},
    '{ 10, 200, 100, 105, 242, 200},
    '{100, 200,  10,  64, 242, 200},
    '{200,  10, 100, 234, 242, 200}
  };

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input int g, input int b,
                       input logic de, input logic hs, input logic vs, input logic en);
    px.red      = 8'(r);
    px.green    = 8'(g);
    px.blue     = 8'(b);
    px.de_in    = de;
    px.hsync_in = hs;
    px.vsync_in = vs;
    ce          = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_H"}, px.H, 8'd0);
    check({tag, "_S"}, px.S, 8'd0);
    check({tag, "_V"}, px.V, 8'd0);
    check({tag, "_de"}, {7'd0, px.de_out}, 8'd0);
    check({tag, "_hs"}, {7'd0, px.hsync_out}, 8'd0);
    check({tag, "_vs"}, {7'd0, px.vsync_out}, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int en_count;
    int cyc;
    logic en;
    logic [7:0] held_h;

    rst = 1'b1;
    ce  = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all_zero("reset");
    rst = 1'b0;

    // Back-to-back vectors, one per enabled cycle.
    for (int c = 0; c < NV + 11; c++) begin
      if (c < NV)
        drive(vec[c][0], vec[c][1], vec[c][2], 1'b1, 1'(c & 1), 1'((c >> 1) & 1), 1'b1);
      else
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c >= 11) begin
        k = c - 11;
        check($sformatf("vec%0d_H", k), px.H, 8'(vec[k][3]));
        check($sformatf("vec%0d_S", k), px.S, 8'(vec[k][4]));
        check($sformatf("vec%0d_V", k), px.V, 8'(vec[k][5]));
        check($sformatf("vec%0d_de", k), {7'd0, px.de_out}, 8'd1);
        check($sformatf("vec%0d_hs", k), {7'd0, px.hsync_out}, 8'(k & 1));
        check($sformatf("vec%0d_vs", k), {7'd0, px.vsync_out}, 8'((k >> 1) & 1));
      end
    end
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_de", {7'd0, px.de_out}, 8'd0);

    // Single pixel with syncs, then ce toggled with random gaps.
    drive(178, 28, 192, 1'b1, 1'b1, 1'b1, 1'b1);
    en_count = 1;
    cyc = 0;
    while (en_count < 12 && cyc < 300) begin
      en = ($urandom_range(0, 2) != 0);
      if (en) drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      else    drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    1'b1, 1'b1, 1'b1, 1'b0);
      cyc++;
      if (en) en_count++;
      if (en_count < 12) check($sformatf("stall_early%0d_de", cyc), {7'd0, px.de_out}, 8'd0);
    end
    check("stall_bound", 8'(en_count), 8'd12);
    check("stall_H", px.H, 8'd208);
    check("stall_S", px.S, 8'd217);
    check("stall_V", px.V, 8'd192);
    check("stall_de", {7'd0, px.de_out}, 8'd1);
    check("stall_hs", {7'd0, px.hsync_out}, 8'd1);
    check("stall_vs", {7'd0, px.vsync_out}, 8'd1);
    held_h = 8'd208;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("hold%0d_H", i), px.H, held_h);
      check($sformatf("hold%0d_V", i), px.V, 8'd192);
      check($sformatf("hold%0d_de", i), {7'd0, px.de_out}, 8'd1);
    end
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("after_hold_de", {7'd0, px.de_out}, 8'd0);

    // Reset with pixels in flight; it also overrides ce=0.
    for (int i = 0; i < 5; i++) drive(50, 100, 250, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    drive(50, 100, 250, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("postrst%0d_de", i), {7'd0, px.de_out}, 8'd0);
      check($sformatf("postrst%0d_V", i), px.V, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
